// File: rtl/thcattus_uart_pkg.sv
// Shared types and helpers for the thcattus UART arbitration blocks.
package thcattus_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  localparam int unsigned BitsPerByte = 8;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/thcattus_rr_arbiter.sv
// Combinational rotate-priority picker: the search starts one past ptr_i and wraps.
module thcattus_rr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  input  logic                en_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_any_o
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      idx = (32'(ptr_i) + k) % NumReq;
      if (en_i && !gnt_any_o && req_i[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_idx_o  = IdxWidth'(idx);
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thcattus_uart_tx_arbiter.sv
// Round-robin AXI-Stream arbiter feeding one UART transmitter through a one-beat output stage.
// Define THCATTUS_UART_ARB_PKTLOCK_EN to keep a packet (tlast-delimited) contiguous.
module thcattus_uart_tx_arbiter
  import thcattus_uart_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = id_width(NUM_PORTS)
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_arestn,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                  s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH*8-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [DATA_WIDTH*8-1:0]               m_axis_tdata,
  output logic [ID_WIDTH-1:0]                   m_axis_tid,
  output logic                                  busy
);

  localparam int unsigned DataBits = DATA_WIDTH * BitsPerByte;

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic                 tvalid_q, tvalid_d;
  logic [DataBits-1:0]  tdata_q, tdata_d;
  logic [ID_WIDTH-1:0]  tid_q, tid_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [ID_WIDTH-1:0]  gnt_idx;
  logic                 gnt_any;
  logic                 arb_en;

`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
  logic last_q, last_d;

  // While locked only the owner of the open packet may be granted.
  assign req    = (state_q == ST_LOCK) ? (s_axis_tvalid & (NUM_PORTS'(1) << tid_q))
                                       : s_axis_tvalid;
  assign arb_en = axis_arestn && ((state_q == ST_IDLE) || (state_q == ST_LOCK));
`else
  logic unused_tlast;
  assign unused_tlast = ^s_axis_tlast;
  assign req          = s_axis_tvalid;
  assign arb_en       = axis_arestn && (state_q == ST_IDLE);
`endif

  thcattus_rr_arbiter #(
    .NumReq   (NUM_PORTS),
    .IdxWidth (ID_WIDTH)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          tdata_d  = s_axis_tdata[32'(gnt_idx) * DataBits +: DataBits];
          tid_d    = gnt_idx;
          tvalid_d = 1'b1;
          ptr_d    = gnt_idx;
          state_d  = ST_HOLD;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
          last_d   = s_axis_tlast[gnt_idx];
`endif
        end
      end
      ST_HOLD: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_IDLE;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
          if (!last_q) state_d = ST_LOCK;
`endif
        end
      end
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
      ST_LOCK: begin
        // Same port as the held packet, so the rotation pointer stays put.
        if (gnt_any) begin
          tdata_d  = s_axis_tdata[32'(gnt_idx) * DataBits +: DataBits];
          tvalid_d = 1'b1;
          last_d   = s_axis_tlast[gnt_idx];
          state_d  = ST_HOLD;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= ID_WIDTH'(NUM_PORTS - 1);
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
      last_q   <= last_d;
`endif
    end
  end

  assign s_axis_tready = gnt;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tid    = tid_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_thcattus_uart_tx_arbiter.sv
// Bench for thcattus_uart_tx_arbiter: directed scenarios plus random traffic against a beat-level model.
module tb_thcattus_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         arestn = 1'b0;
  logic [3:0]   s_tvalid = '0;
  logic [3:0]   s_tready;
  logic [127:0] s_tdata = '0;
  logic [3:0]   s_tlast = '0;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [31:0]  m_tdata;
  logic [1:0]   m_tid;
  logic         busy;

  always #5 clk = ~clk;

  thcattus_uart_tx_arbiter #(
    .NUM_PORTS  (4),
    .DATA_WIDTH (4)
  ) dut (
    .axis_aclk     (clk),
    .axis_arestn   (arestn),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tid    (m_tid),
    .busy          (busy)
  );

  // Per-port traffic: beats still to send and the beat currently offered.
  int          rem [N];
  logic [31:0] dat [N];

  // Beat-level model of the arbiter.
  bit          md_hold, md_lock, md_last;
  int          md_ptr, md_tid;
  logic [31:0] md_data;
  int          glog[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      s_tvalid[p]         = rem[p] > 0;
      s_tlast[p]          = rem[p] == 1;
      s_tdata[p*32 +: 32] = dat[p];
    end
  endtask

  function automatic int pick();
    if (md_lock) return s_tvalid[md_tid] ? md_tid : -1;
    for (int k = 1; k <= N; k++) begin
      if (s_tvalid[(md_ptr + k) % N]) return (md_ptr + k) % N;
    end
    return -1;
  endfunction

  // Check outputs mid-cycle, advance the model, then retire any accepted beat after the edge.
  task automatic cycle();
    int         g;
    logic [3:0] er;
    @(negedge clk);
    g  = md_hold ? -1 : pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("s_tready", s_tready, er);
    chk("m_tvalid", m_tvalid, md_hold);
    chk("m_tdata", m_tdata, md_data);
    chk("m_tid", m_tid, md_tid);
    chk("busy", busy, md_hold || md_lock);
    if (md_hold) begin
      if (m_tready) begin
        md_hold = 1'b0;
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
        md_lock = !md_last;
`endif
      end
    end else if (g >= 0) begin
      md_hold = 1'b1;
      md_data = dat[g];
      md_tid  = g;
      md_last = s_tlast[g];
      if (!md_lock) md_ptr = g;
      glog.push_back(g);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      rem[g]--;
      dat[g] = $urandom;
      drive();
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase with reset released.
  task automatic do_reset();
    arestn = 1'b0;
    #2;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    md_hold = 1'b0;
    md_lock = 1'b0;
    md_last = 1'b0;
    md_ptr  = N - 1;
    md_tid  = 0;
    md_data = '0;
    glog.delete();
    @(posedge clk);
    #1;
    arestn = 1'b1;
  endtask

  task automatic clear_traffic();
    for (int p = 0; p < N; p++) rem[p] = 0;
    drive();
  endtask

  initial begin
    int exp_seq[$];
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      dat[p] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single beat from port 2.
    rem[2]   = 1;
    dat[2]   = 32'hA5A5_0102;
    m_tready = 1'b1;
    drive();
    cycle();
    chk("t1_tvalid", m_tvalid, 1);
    chk("t1_tdata", m_tdata, 32'hA5A5_0102);
    chk("t1_tid", m_tid, 2);
    cycle();
    chk("t1_idle", busy, 0);
    cycle();

    // All ports continuously valid: strict rotation from port 0.
    clear_traffic();
    do_reset();
    for (int p = 0; p < N; p++) begin
      rem[p] = 10;
      dat[p] = $urandom;
    end
    m_tready = 1'b1;
    drive();
    repeat (16) cycle();
    chk("t2_count", glog.size() >= 8, 1);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_order", glog[i], i % N);

    // Back-pressure: output held for 50 cycles.
    clear_traffic();
    do_reset();
    rem[1]   = 1;
    dat[1]   = $urandom;
    m_tready = 1'b0;
    drive();
    repeat (51) cycle();
    chk("t3_tvalid", m_tvalid, 1);
    chk("t3_tid", m_tid, 1);
    chk("t3_busy", busy, 1);
    m_tready = 1'b1;
    repeat (2) cycle();

    // Reset while holding a beat from port 2, with other requests pending.
    clear_traffic();
    do_reset();
    rem[2]   = 1;
    dat[2]   = $urandom;
    m_tready = 1'b0;
    drive();
    repeat (3) cycle();
    rem[1] = 1;
    rem[3] = 1;
    drive();
    do_reset();
    m_tready = 1'b1;
    cycle();
    chk("t4_first_grant", glog.size() > 0 ? glog[0] : -1, 1);
    repeat (4) cycle();

    // Three-beat packet on port 0 against a constantly valid port 1.
    clear_traffic();
    do_reset();
    rem[0] = 3;
    rem[1] = 100;
    dat[0] = $urandom;
    dat[1] = $urandom;
    m_tready = 1'b1;
    drive();
    repeat (10) cycle();
`ifdef THCATTUS_UART_ARB_PKTLOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    chk("t5_count", glog.size() >= exp_seq.size(), 1);
    for (int i = 0; i < exp_seq.size() && i < glog.size(); i++) chk("t5_seq", glog[i], exp_seq[i]);

    // Random traffic and back-pressure.
    clear_traffic();
    do_reset();
    repeat (400) begin
      m_tready = $urandom_range(0, 3) != 0;
      for (int p = 0; p < N; p++) begin
        if (rem[p] == 0 && $urandom_range(0, 3) == 0) begin
          rem[p] = $urandom_range(1, 3);
          dat[p] = $urandom;
        end
      end
      drive();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
